alu32: RTL and testbench

Registered 32-bit integer ALU for the CPU datapath execute stage. Combines two 32-bit operands under a 3-bit operation select and registers the result, a zero flag and a signed-overflow flag on the rising clock edge. Results are consumed by the writeback path; the zero flag drives branch resolution.

---
 rtl/alu32.sv | 97 +++++++++
 tb/tb_alu32.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu32.sv
// Registered 32-bit integer ALU for the execute stage: one shared adder serves ADD, SUB and both
// compares; result, zero and signed-overflow flags are registered with a synchronous reset.
module alu32 (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  ALUControl,
   output logic [31:0] R,
   output logic        zero,
   output logic        ovf
);

   typedef enum logic [2:0] {
      OpAnd  = 3'b000,
      OpOr   = 3'b001,
      OpAdd  = 3'b010,
      OpXor  = 3'b011,
      OpNor  = 3'b100,
      OpSltu = 3'b101,
      OpSub  = 3'b110,
      OpSlt  = 3'b111
   } alu_op_e;

   alu_op_e     op;
   logic        sub_en;
   logic [31:0] b_eff;
   logic [32:0] sum_ext;
   logic [31:0] sum;
   logic        carry;
   logic        add_ovf;
   logic        lt_signed;
   logic        lt_unsigned;

   logic [31:0] r_d, r_q;
   logic        zero_d, zero_q;
   logic        ovf_d, ovf_q;

   assign op = alu_op_e'(ALUControl);

   // SUB and both compares form A + ~B + 1 on the same adder.
   assign sub_en  = (op == OpSub) || (op == OpSlt) || (op == OpSltu);
   assign b_eff   = sub_en ? ~B : B;
   assign sum_ext = {1'b0, A} + {1'b0, b_eff} + {32'b0, sub_en};
   assign sum     = sum_ext[31:0];
   assign carry   = sum_ext[32];

   // b_eff already carries the inversion, so one rule covers ADD and SUB overflow.
   assign add_ovf = (A[31] == b_eff[31]) && (sum[31] != A[31]);

   // Overflow corrects the difference sign, keeping SLT right at the extremes of the range.
   assign lt_signed   = sum[31] ^ add_ovf;
   assign lt_unsigned = ~carry;

   always_comb begin
      r_d   = 32'h0;
      ovf_d = 1'b0;
      unique case (op)
         OpAnd:  r_d = A & B;
         OpOr:   r_d = A | B;
         OpAdd: begin
            r_d   = sum;
            ovf_d = add_ovf;
         end
         OpXor:  r_d = A ^ B;
         OpNor:  r_d = ~(A | B);
         OpSltu: r_d = {31'b0, lt_unsigned};
         OpSub: begin
            r_d   = sum;
            ovf_d = add_ovf;
         end
         OpSlt:  r_d = {31'b0, lt_signed};
         default: begin
            r_d   = 32'h0;
            ovf_d = 1'b0;
         end
      endcase
      zero_d = (r_d == 32'h0);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q    <= 32'h0;
         zero_q <= 1'b1;
         ovf_q  <= 1'b0;
      end else begin
         r_q    <= r_d;
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
      end
   end

   assign R    = r_q;
   assign zero = zero_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_alu32.sv
// Scoreboard bench for alu32: the driver pushes expectations at each falling edge, the monitor pops
// and compares just after each rising edge.
module tb_alu32;

   logic        clk;
   logic        reset;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  ALUControl;
   logic [31:0] R;
   logic        zero;
   logic        ovf;

   typedef struct {
      logic [31:0] r;
      logic        z;
      logic        o;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   alu32 dut (
      .clk       (clk),
      .reset     (reset),
      .A         (A),
      .B         (B),
      .ALUControl(ALUControl),
      .R         (R),
      .zero      (zero),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model from the operation table, using wide signed arithmetic.
   function automatic exp_t model(input bit rst, input bit [31:0] a, input bit [31:0] b,
                                  input bit [2:0] op, input string name);
      exp_t   e;
      longint sa;
      longint sb;
      longint wide;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.r = 32'h0;
      e.o = 1'b0;
      e.name = name;
      if (!rst) begin
         e.z = 1'b1;
         return e;
      end
      case (op)
         3'd0: e.r = a & b;
         3'd1: e.r = a | b;
         3'd2: begin
            wide = sa + sb;
            e.r  = a + b;
            e.o  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         3'd3: e.r = a ^ b;
         3'd4: e.r = ~(a | b);
         3'd5: e.r = (a < b) ? 32'd1 : 32'd0;
         3'd6: begin
            wide = sa - sb;
            e.r  = a - b;
            e.o  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         default: e.r = (sa < sb) ? 32'd1 : 32'd0;
      endcase
      e.z = (e.r == 32'h0);
      return e;
   endfunction

   task automatic drive_exp(input bit rst, input bit [31:0] a, input bit [31:0] b,
                            input bit [2:0] op, input bit [31:0] er, input bit ez,
                            input bit eo, input string name);
      exp_t e;
      reset = rst;
      A = a;
      B = b;
      ALUControl = op;
      e.r = er;
      e.z = ez;
      e.o = eo;
      e.name = name;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic drive_model(input bit rst, input bit [31:0] a, input bit [31:0] b,
                              input bit [2:0] op, input string name);
      reset = rst;
      A = a;
      B = b;
      ALUControl = op;
      exp_q.push_back(model(rst, a, b, op, name));
      @(negedge clk);
   endtask

   // Monitor: one expectation per rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (R !== e.r) begin
               errors++;
               $display("FAIL %s R: got %h want %h", e.name, R, e.r);
            end
            checks++;
            if (zero !== e.z) begin
               errors++;
               $display("FAIL %s zero: got %b want %b", e.name, zero, e.z);
            end
            checks++;
            if (ovf !== e.o) begin
               errors++;
               $display("FAIL %s ovf: got %b want %b", e.name, ovf, e.o);
            end
         end
      end
   end

   initial begin
      bit [31:0] ra;
      bit [31:0] rb;
      bit [2:0]  rop;
      bit        drained;

      for (int i = 0; i < 3; i++) drive_exp(1'b0, 32'd5, 32'd3, 3'b010, 32'h0, 1'b1, 1'b0, "reset");
      drive_exp(1'b1, 32'd5, 32'd3, 3'b010, 32'd8, 1'b0, 1'b0, "add_after_reset");

      drive_exp(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, 1'b0, 1'b0, "and");
      drive_exp(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 32'hFFF0_FFF0, 1'b0, 1'b0, "or");
      drive_exp(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 32'h0FF0_0FF0, 1'b0, 1'b0, "xor");
      drive_exp(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'h000F_000F, 1'b0, 1'b0, "nor");

      drive_exp(1'b1, 32'h7FFF_FFFF, 32'd1, 3'b010, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
      drive_exp(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010, 32'h0, 1'b1, 1'b0, "add_wrap");
      drive_exp(1'b1, 32'h8000_0000, 32'd1, 3'b110, 32'h7FFF_FFFF, 1'b0, 1'b1, "sub_ovf");
      drive_exp(1'b1, 32'd7, 32'd7, 3'b110, 32'h0, 1'b1, 1'b0, "sub_zero");

      drive_exp(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'd1, 1'b0, 1'b0, "slt_extreme");
      drive_exp(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 32'd0, 1'b1, 1'b0, "sltu_extreme");
      drive_exp(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 32'd0, 1'b1, 1'b0, "slt_equal");

      // Back-to-back with a single reset edge mid-stream.
      drive_exp(1'b1, 32'd10, 32'd4, 3'b010, 32'd14, 1'b0, 1'b0, "b2b_add");
      drive_exp(1'b1, 32'd10, 32'd4, 3'b110, 32'd6, 1'b0, 1'b0, "b2b_sub");
      drive_exp(1'b0, 32'h7FFF_FFFF, 32'd1, 3'b010, 32'h0, 1'b1, 1'b0, "b2b_reset");
      drive_exp(1'b1, 32'd3, 32'd9, 3'b101, 32'd1, 1'b0, 1'b0, "b2b_sltu");
      drive_exp(1'b1, 32'h0000_00FF, 32'h0000_0F0F, 3'b011, 32'h0000_0FF0, 1'b0, 1'b0, "b2b_xor");

      for (int i = 0; i < 1000; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rop = 3'($urandom_range(0, 7));
         // Bias some vectors toward sign/equality corner cases.
         if (i % 8 == 0) rb = ra;
         if (i % 8 == 1) ra = {1'b1, 31'($urandom)} ^ 32'h0;
         if (i % 8 == 2) rb = 32'h8000_0000;
         drive_model(1'b1, ra, rb, rop, "random");
      end

      drained = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() == 0) begin
            drained = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!drained) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
